// File: rtl/cfu_cmd_queue_if.sv
// Command handshake bundle between CPU, queue and CFU datapath.
// The slave modport is the queue's view; master is the surrounding environment.
interface cfu_cmd_queue_if #(
   parameter int unsigned DEPTH = 2
);
   localparam int unsigned CW = $clog2(DEPTH + 1);

   logic          in_cmd_valid;
   logic          in_cmd_ready;
   logic [9:0]    in_cmd_payload_function_id;
   logic [31:0]   in_cmd_payload_inputs_0;
   logic [31:0]   in_cmd_payload_inputs_1;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [9:0]    cmd_payload_function_id;
   logic [31:0]   cmd_payload_inputs_0;
   logic [31:0]   cmd_payload_inputs_1;
   logic          flush;
   logic [CW-1:0] count;

   modport slave (
      input  in_cmd_valid,
      input  in_cmd_payload_function_id,
      input  in_cmd_payload_inputs_0,
      input  in_cmd_payload_inputs_1,
      input  cmd_ready,
      input  flush,
      output in_cmd_ready,
      output cmd_valid,
      output cmd_payload_function_id,
      output cmd_payload_inputs_0,
      output cmd_payload_inputs_1,
      output count
   );

   modport master (
      output in_cmd_valid,
      output in_cmd_payload_function_id,
      output in_cmd_payload_inputs_0,
      output in_cmd_payload_inputs_1,
      output cmd_ready,
      output flush,
      input  in_cmd_ready,
      input  cmd_valid,
      input  cmd_payload_function_id,
      input  cmd_payload_inputs_0,
      input  cmd_payload_inputs_1,
      input  count
   );
endinterface

// File: rtl/cfu_cmd_queue.sv
// Registered DEPTH-entry FIFO between the CPU CFU command port and the CFU datapath.
// Downstream payload always shows the head entry; no fall-through and no same-cycle refill.
module cfu_cmd_queue #(
   parameter int unsigned DEPTH = 2
) (
   input logic             clk,
   input logic             reset,
   cfu_cmd_queue_if.slave  bus
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned EW = 74;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   logic [EW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q;
   logic [AW-1:0] wr_ptr_d;
   logic [AW-1:0] rd_ptr_q;
   logic [AW-1:0] rd_ptr_d;
   logic [CW-1:0] count_q;
   logic [CW-1:0] count_d;
   logic          push_s;
   logic          pop_s;
   logic [EW-1:0] head_s;

   // Ready looks only at registered occupancy, flush and reset, never at cmd_ready.
   assign bus.in_cmd_ready = reset & ~bus.flush & (count_q != FULL);
   assign bus.cmd_valid    = (count_q != {CW{1'b0}});
   assign push_s           = bus.in_cmd_valid & bus.in_cmd_ready;
   assign pop_s            = bus.cmd_valid & bus.cmd_ready;

   assign head_s                      = mem_q[rd_ptr_q];
   assign bus.cmd_payload_function_id = head_s[73:64];
   assign bus.cmd_payload_inputs_1    = head_s[63:32];
   assign bus.cmd_payload_inputs_0    = head_s[31:0];
   assign bus.count                   = count_q;

   // Next-state pointers and occupancy; flush overrides any concurrent pop.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (bus.flush) begin
         wr_ptr_d = {AW{1'b0}};
         rd_ptr_d = {AW{1'b0}};
         count_d  = {CW{1'b0}};
      end else begin
         if (push_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
         end else begin
            wr_ptr_d = wr_ptr_q;
         end
         if (pop_s) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else begin
            rd_ptr_d = rd_ptr_q;
         end
         case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // Pointer and occupancy registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_q <= {AW{1'b0}};
         rd_ptr_q <= {AW{1'b0}};
         count_q  <= {CW{1'b0}};
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Entry storage; cleared by reset so payload reads zero, left intact by flush.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= {EW{1'b0}};
         end
      end else if (push_s) begin
         mem_q[wr_ptr_q] <= {bus.in_cmd_payload_function_id,
                             bus.in_cmd_payload_inputs_1,
                             bus.in_cmd_payload_inputs_0};
      end
   end
endmodule

// File: tb/tb_cfu_cmd_queue.sv
// Directed bench for cfu_cmd_queue (DEPTH = 2) with a small scoreboard for the random-stall phase.
module tb_cfu_cmd_queue;
   localparam int unsigned DEPTH = 2;

   logic        clk = 1'b0;
   logic        reset;
   int          checks = 0;
   int          errors = 0;
   logic [73:0] head_s;
   logic [73:0] sb [$];
   logic [73:0] e;
   logic        pu;
   logic        po;

   cfu_cmd_queue_if #(.DEPTH(DEPTH)) bus ();
   cfu_cmd_queue #(.DEPTH(DEPTH)) dut (.clk(clk), .reset(reset), .bus(bus));

   always #5 clk = ~clk;

   assign head_s = {bus.cmd_payload_function_id, bus.cmd_payload_inputs_1, bus.cmd_payload_inputs_0};

   function automatic logic [73:0] pack(input logic [9:0] f, input logic [31:0] a0, input logic [31:0] a1);
      return {f, a1, a0};
   endfunction

   task automatic check(input string tag, input logic [73:0] obs, input logic [73:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [73:0] p);
      bus.in_cmd_valid               = v;
      bus.in_cmd_payload_function_id = p[73:64];
      bus.in_cmd_payload_inputs_1    = p[63:32];
      bus.in_cmd_payload_inputs_0    = p[31:0];
   endtask

   initial begin
      reset = 1'b0;
      bus.flush = 1'b0;
      bus.cmd_ready = 1'b0;
      drive(1'b0, 74'd0);

      // reset / idle
      for (int i = 0; i < 3; i++) begin
         tick();
         check("rst_valid", 74'(bus.cmd_valid), 74'd0);
         check("rst_count", 74'(bus.count), 74'd0);
         check("rst_payload", head_s, 74'd0);
         check("rst_in_ready", 74'(bus.in_cmd_ready), 74'd0);
      end
      reset = 1'b1;
      #1;
      check("rel_in_ready", 74'(bus.in_cmd_ready), 74'd1);

      // single command
      bus.cmd_ready = 1'b1;
      drive(1'b1, pack(10'h001, 32'h0102_0304, 32'h0506_0708));
      #1;
      check("single_pre_valid", 74'(bus.cmd_valid), 74'd0);
      tick();
      drive(1'b0, 74'd0);
      check("single_valid", 74'(bus.cmd_valid), 74'd1);
      check("single_payload", head_s, pack(10'h001, 32'h0102_0304, 32'h0506_0708));
      check("single_count1", 74'(bus.count), 74'd1);
      tick();
      check("single_count0", 74'(bus.count), 74'd0);
      check("single_drained", 74'(bus.cmd_valid), 74'd0);

      // fill and back-pressure
      bus.cmd_ready = 1'b0;
      drive(1'b1, pack(10'h000, 32'hA000_0000, 32'hA000_0001));
      tick();
      drive(1'b1, pack(10'h002, 32'hB000_0000, 32'hB000_0001));
      tick();
      check("full_in_ready", 74'(bus.in_cmd_ready), 74'd0);
      check("full_count", 74'(bus.count), 74'd2);
      drive(1'b1, pack(10'h003, 32'hC000_0000, 32'hC000_0001));
      tick();
      check("full_hold_count", 74'(bus.count), 74'd2);
      check("full_hold_payload", head_s, pack(10'h000, 32'hA000_0000, 32'hA000_0001));
      bus.cmd_ready = 1'b1;
      tick();
      check("popA_count", 74'(bus.count), 74'd1);
      check("popA_head_B", head_s, pack(10'h002, 32'hB000_0000, 32'hB000_0001));
      check("popA_in_ready", 74'(bus.in_cmd_ready), 74'd1);
      tick();
      drive(1'b0, 74'd0);
      check("popB_pushC_count", 74'(bus.count), 74'd1);
      check("popB_head_C", head_s, pack(10'h003, 32'hC000_0000, 32'hC000_0001));
      tick();
      check("popC_count", 74'(bus.count), 74'd0);

      // streaming 100 back-to-back commands
      bus.cmd_ready = 1'b1;
      for (int i = 0; i < 100; i++) begin
         drive(1'b1, pack(10'(i), 32'h1000_0000 + 32'(i), ~(32'h1000_0000 + 32'(i))));
         tick();
         check("stream_count", 74'(bus.count), 74'd1);
         check("stream_payload", head_s, pack(10'(i), 32'h1000_0000 + 32'(i), ~(32'h1000_0000 + 32'(i))));
      end
      drive(1'b0, 74'd0);
      tick();
      check("stream_end_count", 74'(bus.count), 74'd0);

      // push every cycle with random downstream stalls, checked against a scoreboard
      for (int c = 0; c < 40; c++) begin
         e = pack(10'(200 + c), 32'hC0DE_0000 + 32'(c), 32'h0F0F_0000 ^ 32'(c));
         drive(1'b1, e);
         bus.cmd_ready = 1'($urandom_range(0, 1));
         #1;
         pu = (sb.size() < int'(DEPTH));
         po = (sb.size() != 0) && bus.cmd_ready;
         check("rnd_in_ready", 74'(bus.in_cmd_ready), 74'(pu));
         tick();
         if (po) void'(sb.pop_front());
         if (pu) sb.push_back(e);
         check("rnd_count", 74'(bus.count), 74'(sb.size()));
         check("rnd_valid", 74'(bus.cmd_valid), 74'(sb.size() != 0));
         if (sb.size() != 0) check("rnd_head", head_s, sb[0]);
      end
      drive(1'b0, 74'd0);
      bus.cmd_ready = 1'b1;
      tick();
      tick();
      check("rnd_drain_count", 74'(bus.count), 74'd0);
      sb.delete();

      // flush with concurrent pop and push attempt
      bus.cmd_ready = 1'b0;
      drive(1'b1, pack(10'h03D, 32'hDDDD_0000, 32'hDDDD_0001));
      tick();
      drive(1'b1, pack(10'h03E, 32'hEEEE_0000, 32'hEEEE_0001));
      tick();
      check("pre_flush_count", 74'(bus.count), 74'd2);
      bus.flush = 1'b1;
      bus.cmd_ready = 1'b1;
      drive(1'b1, pack(10'h03F, 32'hFFFF_0000, 32'hFFFF_0001));
      #1;
      check("flush_in_ready", 74'(bus.in_cmd_ready), 74'd0);
      tick();
      bus.flush = 1'b0;
      drive(1'b0, 74'd0);
      check("flush_count", 74'(bus.count), 74'd0);
      check("flush_valid", 74'(bus.cmd_valid), 74'd0);
      tick();
      check("flush_stays_empty", 74'(bus.count), 74'd0);

      // refill, then asynchronous reset between edges
      bus.cmd_ready = 1'b0;
      drive(1'b1, pack(10'h040, 32'h4000_0000, 32'h4000_0001));
      tick();
      check("refill_head", head_s, pack(10'h040, 32'h4000_0000, 32'h4000_0001));
      check("refill_count1", 74'(bus.count), 74'd1);
      drive(1'b1, pack(10'h041, 32'h4100_0000, 32'h4100_0001));
      tick();
      drive(1'b0, 74'd0);
      check("refill_count2", 74'(bus.count), 74'd2);
      #2;
      reset = 1'b0;
      #1;
      check("async_valid", 74'(bus.cmd_valid), 74'd0);
      check("async_count", 74'(bus.count), 74'd0);
      check("async_payload", head_s, 74'd0);
      check("async_in_ready", 74'(bus.in_cmd_ready), 74'd0);
      tick();
      reset = 1'b1;
      #1;
      check("rerel_in_ready", 74'(bus.in_cmd_ready), 74'd1);
      bus.cmd_ready = 1'b1;
      drive(1'b1, pack(10'h050, 32'h5000_0000, 32'h5000_0001));
      tick();
      drive(1'b0, 74'd0);
      check("post_rst_head", head_s, pack(10'h050, 32'h5000_0000, 32'h5000_0001));
      check("post_rst_count", 74'(bus.count), 74'd1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cfu_cmd_queue.md
# cfu_cmd_queue

Registered command queue between the CPU's CFU command port and the combinational CFU datapath. It accepts commands (function id plus two 32-bit operands) on a valid/ready handshake and stores them in a DEPTH-entry FIFO. It replays them in order on a second valid/ready port that drives the CFU's cmd_* inputs. Every downstream output comes from a register, which removes the CPU-to-CFU combinational path and absorbs CFU back-pressure without stalling the CPU for DEPTH commands.

## Interface
- DEPTH, 2: number of queue entries; power of two, ≥ 2.
- CW, derived = $clog2(DEPTH+1): width of the occupancy output.

- clk  input  1  sole clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- in_cmd_valid  input  1  upstream command present.
- in_cmd_ready  output  1  queue can accept this cycle.
- in_cmd_payload_function_id  input  10  upstream function id.
- in_cmd_payload_inputs_0  input  32  upstream operand 0.
- in_cmd_payload_inputs_1  input  32  upstream operand 1.
- cmd_valid  output  1  head entry valid toward CFU.
- cmd_ready  input  1  CFU consumes head this cycle.
- cmd_payload_function_id  output  10  head function id.
- cmd_payload_inputs_0  output  32  head operand 0.
- cmd_payload_inputs_1  output  32  head operand 1.
- flush  input  1  synchronous clear of all queued entries.
- count  output  CW  current occupancy, 0..DEPTH.

## Operation
- Storage: DEPTH × 74-bit entries, organised as {function_id, inputs_1, inputs_0}.
- Pointers: write pointer wr_ptr and read pointer rd_ptr, each log2(DEPTH) bits, plus the registered count.
- Pointer wrap: each pointer wraps DEPTH-1 → 0 by natural overflow.
- push = in_cmd_valid & in_cmd_ready.
- pop = cmd_valid & cmd_ready.
- in_cmd_ready = reset & !flush & (count != DEPTH). It depends only on registered state and flush, never on cmd_ready.
- cmd_valid = (count != 0). Payload outputs always show entry[rd_ptr].
- Push only: write entry[wr_ptr], wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop in the same cycle (0 < count < DEPTH): both happen, count unchanged, order preserved.
- Full (count == DEPTH): in_cmd_ready = 0. A pop that cycle frees a slot visible the next cycle. There is no same-cycle refill.
- Empty (count == 0): cmd_valid = 0 and cmd_ready is ignored. A push that cycle appears on cmd_valid the next cycle. There is no fall-through.
- flush = 1: wr_ptr, rd_ptr and count go to 0 at the next edge. A concurrent pop is discarded. No push occurs because in_cmd_ready = 0. Flush overrides everything.
- Payload/entry storage is not cleared by flush. The payload is don't-care while cmd_valid = 0.
- Ordering: strictly FIFO. No command is dropped except by flush or reset.

## Timing
- Reset assertion (reset = 0), asynchronous: count = 0, wr_ptr = rd_ptr = 0, cmd_valid = 0, in_cmd_ready = 0, all cmd_payload_* = 0.
- Reset mid-operation: all queued commands are lost. Outputs reach reset values without waiting for a clock edge.
- First edge after release: in_cmd_ready = 1 combinationally once reset = 1. The first push can land on that edge.
- Latency: a command accepted at edge N is presented on cmd_* from edge N through the edge at which it is popped. This is 1 cycle when the queue is empty.
- Throughput: one push and one pop per cycle in steady state. Full rate needs DEPTH ≥ 2.
- Handshake stability: while cmd_valid = 1 and cmd_ready = 0, cmd_payload_* and cmd_valid hold constant.
- count updates at the edge on which a push or pop takes effect.

## Test plan
- Reset/idle: hold reset = 0 for 3 cycles, then release. Required: cmd_valid = 0, count = 0 and payload = 0 during reset; in_cmd_ready = 1 after release.
- Single command: push fid = 0x001, in0 = 0x01020304, in1 = 0x05060708 with cmd_ready = 1. Required: cmd_valid = 1 exactly one cycle later with identical payload; count goes 0 → 1 → 0.
- Fill and back-pressure (DEPTH = 2): cmd_ready = 0; push A (fid 0x000), B (fid 0x002), and attempt C. Required: in_cmd_ready = 0 after B and count = 2; C is not accepted. Then set cmd_ready = 1: A and B pop in order and C is accepted one cycle after the first pop.
- Streaming: 100 back-to-back commands with in_cmd_valid = 1 and cmd_ready = 1. Required: 100 outputs in order, no gaps after the first, count stays 1.
- Simultaneous push/pop at count = 1 with random cmd_ready stalls. Required: count never changes on a cycle with both push and pop, and the scoreboard matches.
- Flush and async reset: fill 2 entries, pulse flush with cmd_ready = 1. Required: count = 0 and cmd_valid = 0 next cycle, no pop observed by the scoreboard. Then refill, assert reset between clock edges. Required: cmd_valid drops immediately.
